lc3_instr_monitor: RTL and testbench

- Passive testbench stage directly upstream of the DUT assertion checker.
- Snoops the LC-3 memory bus and datapath control strobes, and captures each fetched instruction.
- Produces the registered decoded fields consumed by the assertion module: opcode, register fields, sign-extended offsets and NZP bits.
- Also checks the number of memory accesses per instruction and keeps a fetch counter and an optional PC history ring.

---
 rtl/lc3_mon_pkg.sv | 78 +++++++
 rtl/lc3_hist_ring.sv | 36 +++
 rtl/lc3_instr_monitor.sv | 154 +++++++++++++++
 tb/tb_lc3_instr_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mon_pkg.sv
// Shared types and helpers for the LC-3 instruction monitor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: opcode_t, expected per-instruction memory access counts,
//   sext() sign extension, cc_sets() NZP-writer predicate, access expectations.
package lc3_mon_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'd0,
    OP_ADD  = 4'd1,
    OP_LD   = 4'd2,
    OP_ST   = 4'd3,
    OP_JSR  = 4'd4,
    OP_AND  = 4'd5,
    OP_LDR  = 4'd6,
    OP_STR  = 4'd7,
    OP_RTI  = 4'd8,
    OP_NOT  = 4'd9,
    OP_LDI  = 4'd10,
    OP_STI  = 4'd11,
    OP_JMP  = 4'd12,
    OP_RES  = 4'd13,
    OP_LEA  = 4'd14,
    OP_TRAP = 4'd15
  } opcode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } mon_state_t;

  // Every read count includes the MDR load of the following fetch.
  localparam logic [2:0] RD_EXP_LD      = 3'd2;  // LD and LDR
  localparam logic [2:0] RD_EXP_LDI     = 3'd3;
  localparam logic [2:0] RD_EXP_STI     = 3'd2;
  localparam logic [2:0] RD_EXP_TRAP    = 3'd2;
  localparam logic [2:0] RD_EXP_DEFAULT = 3'd1;
  localparam logic [2:0] WR_EXP_STORE   = 3'd1;  // ST, STR, STI
  localparam logic [2:0] WR_EXP_DEFAULT = 3'd0;
  localparam logic [2:0] CNT_SAT        = 3'd7;

  // Sign-extend the low 'width' bits of value to 16 bits.
  function automatic logic [15:0] sext(input logic [15:0] value, input int width);
    logic [15:0] shl;
    shl = value << (16 - width);
    return $unsigned($signed(shl) >>> (16 - width));
  endfunction

  function automatic logic cc_sets(input opcode_t op);
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDI, OP_LDR, OP_LEA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_rd(input opcode_t op);
    case (op)
      OP_LD, OP_LDR: return RD_EXP_LD;
      OP_LDI:        return RD_EXP_LDI;
      OP_STI:        return RD_EXP_STI;
      OP_TRAP:       return RD_EXP_TRAP;
      default:       return RD_EXP_DEFAULT;
    endcase
  endfunction

  function automatic logic [2:0] exp_wr(input opcode_t op);
    case (op)
      OP_ST, OP_STR, OP_STI: return WR_EXP_STORE;
      default:               return WR_EXP_DEFAULT;
    endcase
  endfunction

  // RTI and the reserved opcode have no defined access pattern.
  function automatic logic check_skip(input opcode_t op);
    return (op == OP_RTI) || (op == OP_RES);
  endfunction

endpackage

// File: rtl/lc3_hist_ring.sv
// Ring of the most recent fetch PCs, readable by age (0 = newest).
// Latency: write on the fetch edge, read is combinational.
// Backpressure: none; every write is accepted.
// Ports: clk, reset (sync, active-high), wr_en/wr_pc write port,
//   rd_idx age select, rd_pc selected entry (0 if never written).
module lc3_hist_ring #(
  parameter int HIST_DEPTH = 8,
  parameter int IDX_W      = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [15:0]      wr_pc,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [15:0]      rd_pc
);

  logic [15:0]      ring [HIST_DEPTH];
  logic [IDX_W-1:0] wptr;
  logic [IDX_W-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) ring[i] <= 16'h0000;
    end else if (wr_en) begin
      ring[wptr] <= wr_pc;
      wptr       <= wptr + 1'b1;
    end
  end

  // Power-of-two depth: pointer arithmetic wraps naturally.
  assign rd_addr = wptr - 1'b1 - rd_idx;
  assign rd_pc   = ring[rd_addr];

endmodule

// File: rtl/lc3_instr_monitor.sv
// Passive LC-3 bus monitor: captures fetched instructions, decodes fields, checks access counts.
// Latency: fields/instr_valid/access_err appear one cycle after the ld_ir edge.
// Backpressure: none; purely observes the bus and never stalls the DUT.
// Ports: clk, reset (sync, active-high); bus snoop address/dataFromMemory/ld_ir/mem_rd/mem_we/
//   pc_at_fetch; decoded outputs (instruction, opcode, register fields, offsets, NZP, cc_update);
//   access_err pulse; instr_count; hist_rd_idx/hist_pc history read (needs LC3_MON_HISTORY_EN).
module lc3_instr_monitor
  import lc3_mon_pkg::*;
#(
  parameter int HIST_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   address,
  input  logic [15:0]                   dataFromMemory,
  input  logic                          ld_ir,
  input  logic                          mem_rd,
  input  logic                          mem_we,
  input  logic [15:0]                   pc_at_fetch,
  output logic                          instr_valid,
  output logic [15:0]                   instruction,
  output logic [3:0]                    opcode,
  output logic [2:0]                    dr,
  output logic [2:0]                    sr1,
  output logic [2:0]                    sr2,
  output logic [2:0]                    base_r,
  output logic                          imm_sw,
  output logic                          jsr_sw,
  output logic                          br_n,
  output logic                          br_z,
  output logic                          br_p,
  output logic [15:0]                   imm5,
  output logic [15:0]                   pcoffset6,
  output logic [15:0]                   pcoffset9,
  output logic [15:0]                   pcoffset11,
  output logic [7:0]                    trapvect8,
  output logic [15:0]                   fetch_pc,
  output logic                          cc_update,
  output logic                          access_err,
  output logic [CNT_W-1:0]              instr_count,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [15:0]                   hist_pc
);

  mon_state_t state, state_nxt;
  logic       count_en;
  logic       do_check;

  logic [2:0] rd_cnt, wr_cnt;
  logic [2:0] rd_final, wr_final;
  logic       mismatch;
  opcode_t    op;

  // The address bus is only snooped for debug visibility; nothing depends on it.
  logic unused_address;
  assign unused_address = ^address;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    count_en  = 1'b0;
    do_check  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_ir) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        count_en = 1'b1;
        do_check = ld_ir;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- access counting ----------------
  // Final counts include strobes in the current cycle, so a read that
  // coincides with ld_ir is charged to the outgoing instruction.
  assign rd_final = (rd_cnt == CNT_SAT) ? CNT_SAT : rd_cnt + {2'b00, mem_rd};
  assign wr_final = (wr_cnt == CNT_SAT) ? CNT_SAT : wr_cnt + {2'b00, mem_we};

  assign op       = opcode_t'(instruction[15:12]);
  assign mismatch = !check_skip(op) &&
                    ((rd_final != exp_rd(op)) || (wr_final != exp_wr(op)));

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= 16'h0000;
      fetch_pc    <= 16'h0000;
      instr_valid <= 1'b0;
      access_err  <= 1'b0;
      instr_count <= '0;
      rd_cnt      <= 3'd0;
      wr_cnt      <= 3'd0;
    end else begin
      instr_valid <= ld_ir;
      access_err  <= do_check && mismatch;
      if (ld_ir) begin
        instruction <= dataFromMemory;
        fetch_pc    <= pc_at_fetch;
        instr_count <= instr_count + 1'b1;
        rd_cnt      <= 3'd0;
        wr_cnt      <= 3'd0;
      end else if (count_en) begin
        rd_cnt <= rd_final;
        wr_cnt <= wr_final;
      end
    end
  end

  // ---------------- decode ----------------
  // Fields are pure slices of the registered instruction, so they update on
  // the capture edge and hold until the next fetch; reset clears them to 0.
  assign opcode     = instruction[15:12];
  assign dr         = instruction[11:9];
  assign sr1        = instruction[8:6];
  assign sr2        = instruction[2:0];
  assign base_r     = instruction[8:6];
  assign imm_sw     = instruction[5];
  assign jsr_sw     = instruction[11];
  assign br_n       = instruction[11];
  assign br_z       = instruction[10];
  assign br_p       = instruction[9];
  assign imm5       = sext(instruction, 5);
  assign pcoffset6  = sext(instruction, 6);
  assign pcoffset9  = sext(instruction, 9);
  assign pcoffset11 = sext(instruction, 11);
  assign trapvect8  = instruction[7:0];
  assign cc_update  = cc_sets(op);

  // ---------------- optional PC history ----------------
`ifdef LC3_MON_HISTORY_EN
  lc3_hist_ring #(
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (ld_ir),
    .wr_pc  (pc_at_fetch),
    .rd_idx (hist_rd_idx),
    .rd_pc  (hist_pc)
  );
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_rd_idx;
  assign hist_pc         = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3_instr_monitor.sv
// Directed self-checking bench for lc3_instr_monitor.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: n/a.
module tb_lc3_instr_monitor;

  localparam int HIST_DEPTH = 8;
  localparam int CNT_W      = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [15:0] dataFromMemory;
  logic        ld_ir, mem_rd, mem_we;
  logic [15:0] pc_at_fetch;
  logic [2:0]  hist_rd_idx;

  logic             instr_valid;
  logic [15:0]      instruction;
  logic [3:0]       opcode;
  logic [2:0]       dr, sr1, sr2, base_r;
  logic             imm_sw, jsr_sw, br_n, br_z, br_p;
  logic [15:0]      imm5, pcoffset6, pcoffset9, pcoffset11;
  logic [7:0]       trapvect8;
  logic [15:0]      fetch_pc;
  logic             cc_update;
  logic             access_err;
  logic [CNT_W-1:0] instr_count;
  logic [15:0]      hist_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_instr_monitor #(
    .HIST_DEPTH (HIST_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .dataFromMemory (dataFromMemory),
    .ld_ir          (ld_ir),
    .mem_rd         (mem_rd),
    .mem_we         (mem_we),
    .pc_at_fetch    (pc_at_fetch),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .opcode         (opcode),
    .dr             (dr),
    .sr1            (sr1),
    .sr2            (sr2),
    .base_r         (base_r),
    .imm_sw         (imm_sw),
    .jsr_sw         (jsr_sw),
    .br_n           (br_n),
    .br_z           (br_z),
    .br_p           (br_p),
    .imm5           (imm5),
    .pcoffset6      (pcoffset6),
    .pcoffset9      (pcoffset9),
    .pcoffset11     (pcoffset11),
    .trapvect8      (trapvect8),
    .fetch_pc       (fetch_pc),
    .cc_update      (cc_update),
    .access_err     (access_err),
    .instr_count    (instr_count),
    .hist_rd_idx    (hist_rd_idx),
    .hist_pc        (hist_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; inputs return to idle afterwards.
  task automatic cyc(input logic ld, input logic rd, input logic we,
                     input logic [15:0] data, input logic [15:0] pc);
    ld_ir = ld; mem_rd = rd; mem_we = we;
    dataFromMemory = data; pc_at_fetch = pc; address = pc;
    @(posedge clk);
    #1;
    ld_ir = 1'b0; mem_rd = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; dataFromMemory = '0;
    ld_ir = 1'b0; mem_rd = 1'b0; mem_we = 1'b0; pc_at_fetch = '0; hist_rd_idx = '0;

    // Reset for two cycles, including strobes that must be ignored.
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h1234);
    reset = 1'b0;
    chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",  {16'd0, instruction}, 32'd0);
    chk("rst_count",  instr_count,          32'd0);
    chk("rst_err",    {31'd0, access_err},  32'd0);
    chk("rst_imm5",   {16'd0, imm5},        32'd0);
    chk("rst_fpc",    {16'd0, fetch_pc},    32'd0);
    chk("rst_cc",     {31'd0, cc_update},   32'd0);

    // ADD R1,R2,#-3 from S_IDLE.
    cyc(1'b1, 1'b1, 1'b0, 16'h12BD, 16'h3000);
    chk("add_valid",  {31'd0, instr_valid}, 32'd1);
    chk("add_op",     {28'd0, opcode},      32'd1);
    chk("add_dr",     {29'd0, dr},          32'd1);
    chk("add_sr1",    {29'd0, sr1},         32'd2);
    chk("add_sr2",    {29'd0, sr2},         32'd5);
    chk("add_immsw",  {31'd0, imm_sw},      32'd1);
    chk("add_imm5",   {16'd0, imm5},        32'h0000FFFD);
    chk("add_cc",     {31'd0, cc_update},   32'd1);
    chk("add_fpc",    {16'd0, fetch_pc},    32'h00003000);
    chk("add_count",  instr_count,          32'd1);
    chk("add_err",    {31'd0, access_err},  32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("valid_pulse", {31'd0, instr_valid}, 32'd0);

    // LDI R2,#-2 ; ADD window had exactly the fetch read.
    cyc(1'b1, 1'b1, 1'b0, 16'hA5FE, 16'h3001);
    chk("ldi_op",     {28'd0, opcode},      32'd10);
    chk("ldi_off9",   {16'd0, pcoffset9},   32'h0000FFFE);
    chk("ldi_off6",   {16'd0, pcoffset6},   32'h0000FFFE);
    chk("ldi_off11",  {16'd0, pcoffset11},  32'h0000FDFE);
    chk("ldi_trap8",  {24'd0, trapvect8},   32'h000000FE);
    chk("ldi_nzp",    {29'd0, br_n, br_z, br_p}, 32'b010);
    chk("add_to_ldi_err", {31'd0, access_err}, 32'd0);

    // LDI with 2 data reads + fetch read -> 3, correct.
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h12BD, 16'h3002);
    chk("ldi_ok_err", {31'd0, access_err},  32'd0);
    chk("ldi_count",  instr_count,          32'd3);

    // LDI with only 1 data read -> mismatch, single-cycle pulse.
    cyc(1'b1, 1'b1, 1'b0, 16'hA5FE, 16'h3003);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h3200, 16'h3004);
    chk("ldi_short_err", {31'd0, access_err}, 32'd1);
    chk("st_op",      {28'd0, opcode},      32'd3);
    chk("st_cc",      {31'd0, cc_update},   32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("err_pulse",  {31'd0, access_err},  32'd0);

    // ST without a write -> mismatch.
    cyc(1'b1, 1'b1, 1'b0, 16'h3200, 16'h3005);
    chk("st_nowr_err", {31'd0, access_err}, 32'd1);
    // ST with its write -> clean.
    cyc(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h12BD, 16'h3006);
    chk("st_wr_err",  {31'd0, access_err},  32'd0);

    // Saturated read counter on ADD -> mismatch; then RTI is never flagged.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h8000, 16'h3007);
    chk("sat_err",    {31'd0, access_err},  32'd1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'hF025, 16'h3008);
    chk("rti_skip_err", {31'd0, access_err}, 32'd0);
    chk("trap_vec",   {24'd0, trapvect8},   32'h00000025);

    // Reset during S_EXEC with ld_ir high: reset wins.
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 16'h5020, 16'h3009);
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", {16'd0, instruction}, 32'd0);
    chk("mid_rst_count", instr_count,          32'd0);
    chk("mid_rst_hist",  {16'd0, hist_pc},     32'd0);
    // First fetch after reset: no check even with no reads counted.
    cyc(1'b1, 1'b0, 1'b0, 16'h5020, 16'h4000);
    chk("post_rst_err",   {31'd0, access_err}, 32'd0);
    chk("post_rst_op",    {28'd0, opcode},     32'd5);
    chk("post_rst_count", instr_count,         32'd1);

`ifdef LC3_MON_HISTORY_EN
    hist_rd_idx = 3'd0; #1;
    chk("hist_first", {16'd0, hist_pc}, 32'h00004000);
    hist_rd_idx = 3'd1; #1;
    chk("hist_unwritten", {16'd0, hist_pc}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 16'h12BD, 16'h3000 + 16'(i));
    hist_rd_idx = 3'd0; #1;
    chk("hist_idx0", {16'd0, hist_pc}, 32'h00003009);
    hist_rd_idx = 3'd7; #1;
    chk("hist_idx7", {16'd0, hist_pc}, 32'h00003002);
`else
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 16'h12BD, 16'h3000 + 16'(i));
    hist_rd_idx = 3'd0; #1;
    chk("hist_off_idx0", {16'd0, hist_pc}, 32'd0);
    hist_rd_idx = 3'd7; #1;
    chk("hist_off_idx7", {16'd0, hist_pc}, 32'd0);
`endif
    chk("final_count", instr_count, 32'd11);
    chk("final_fpc",   {16'd0, fetch_pc}, 32'h00003009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
